bf_sequencer: RTL and testbench
===============================

Name: bf_sequencer

Overview:
- Instruction sequencer for the BrainFuck datapath: fetches opcodes from code memory, executes them against data memory and the input/output queues, and tracks loops with a hardware bracket stack.
- Replaces edge-triggered pointer strobes with a single-clock FSM that owns the code pointer, data pointer and queue handshakes.
- Sits between the cod/dat RAMs and the qui/quo queues.

Parameters:
- BITSIZE, 8: cell and opcode width.
- STKSIZE, 12: loop stack depth, in entries.
- DADDLEN, 10: data address width; data pointer wraps mod 2^DADDLEN.
- CADDLEN, 10: code address width.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  begin execution at pc=0, ptr=0; honoured only in IDLE, HALT or ERR.
- cod_addr  out  CADDLEN  code read address (=pc).
- cod_data  in  BITSIZE  combinational code read data for cod_addr.
- dat_addr  out  DADDLEN  data address (=ptr).
- dat_rdata  in  BITSIZE  combinational data read for dat_addr.
- dat_wdata  out  BITSIZE  write data.
- dat_we  out  1  write strobe, one cycle.
- in_valid  in  1  input queue non-empty.
- in_data  in  BITSIZE  input queue head.
- in_pop  out  1  pop input head, one cycle.
- out_full  in  1  output queue full.
- out_data  out  BITSIZE  output push data.
- out_push  out  1  push strobe, one cycle.
- busy  out  1  state is RUN or SKIP.
- done  out  1  state is HALT.
- err  out  1  state is ERR.

Behaviour:
- Reset: state=IDLE, pc=0, ptr=0, sp=0, depth=0. All strobes 0, busy/done/err 0, dat_wdata and out_data 0. RST wins over every other input, including mid-run and mid-SKIP.
- States: IDLE, RUN, SKIP, HALT, ERR.
- START in IDLE/HALT/ERR moves to RUN and clears pc, ptr, sp and depth. Data RAM contents are not cleared. START is ignored in RUN and SKIP.
- RUN executes one opcode per cycle, decoding cod_data:
  - 0x2B '+': dat_we=1, dat_wdata=dat_rdata+1 mod 2^BITSIZE; pc+1.
  - 0x2D '-': dat_we=1, dat_wdata=dat_rdata-1 mod 2^BITSIZE; pc+1.
  - 0x3E '>': ptr+1, wrapping mod 2^DADDLEN; pc+1.
  - 0x3C '<': ptr-1, wrapping mod 2^DADDLEN; pc+1.
  - 0x2E '.': if !out_full, out_push=1, out_data=dat_rdata, pc+1. Otherwise stall: no pc change, no strobe.
  - 0x2C ',': if in_valid, in_pop=1, dat_we=1, dat_wdata=in_data, pc+1. Otherwise stall.
  - 0x5B '[':
    - dat_rdata!=0: push pc, pc+1. If sp==STKSIZE, go to ERR with no push.
    - dat_rdata==0: depth=1, pc+1, go to SKIP.
  - 0x5D ']':
    - sp==0: go to ERR.
    - dat_rdata!=0: pc=stack[sp-1]+1; stack unchanged.
    - dat_rdata==0: pop, pc+1.
  - 0x00: go to HALT; pc unchanged.
  - Any other byte: NOP, pc+1.
- SKIP: one code byte per cycle, no data or queue side effects.
  - '[' increments depth.
  - ']' decrements depth; when depth reaches 0, pc+1 and return to RUN.
  - 0x00 goes to ERR (unmatched '[').
  - Otherwise pc+1.
  - depth is CADDLEN+1 bits wide.
- End of code: advancing pc past 2^CADDLEN-1 (RUN or SKIP) goes to HALT instead of wrapping.
- Loop latency: a taken ']' lands on the first body opcode, executed the next cycle. No bubbles anywhere except stalls.
- Strobes are combinational from state and inputs, asserted only in the cycle the opcode retires. A stalled cycle asserts nothing.
- HALT and ERR hold pc and ptr for debug readback via cod_addr/dat_addr. No strobes are asserted in either state.

Test Plan:
- Code "+++." then 0x00, RAM zero, out_full=0 → 3 dat_we cycles writing 1,2,3; out_push once with out_data=3; done=1 in cycle 5 after START.
- Code ",[-.]" then 0x00, in_data=2 valid → in_pop once, dat writes 2,1,0; out_push data 1 then 0; done=1; sp=0 at HALT.
- Code "[+++]." with cell=0 → SKIP over 3 '+' with zero dat_we; out_push with out_data=0; then HALT.
- Code "." with out_full held 1 for 4 cycles → pc stays 0, no out_push for 4 cycles; push on the cycle out_full drops.
- Code of 13 nested '[' with cell=1 (STKSIZE=12) → err=1 on the 13th '['; "]" alone → err=1; "[[]" with cell=0 → err at 0x00.
- Code "<" with ptr=0 → ptr=1023; RST asserted mid-SKIP → IDLE, all outputs zero next cycle.

Source files
------------

// File: rtl/bf_sequencer.sv
// bf_sequencer: single-clock BrainFuck instruction sequencer.
// Fetches one opcode per cycle from code memory, executes it against the data
// RAM and the input/output queues, and tracks loops with a bracket stack.
// Ports:
//   CLK, RST (sync active-high), START  - clock, reset, begin execution
//   cod_addr/cod_data                   - code RAM read port (pc)
//   dat_addr/dat_rdata/dat_wdata/dat_we - data RAM port (ptr)
//   in_valid/in_data/in_pop             - input queue head and pop strobe
//   out_full/out_data/out_push          - output queue push
//   busy/done/err                       - RUN|SKIP, HALT, ERR status
// Strobes and write data are combinational from state and inputs so an opcode
// retires in the same cycle it is fetched.
module bf_sequencer #(
  parameter int unsigned BITSIZE = 8,
  parameter int unsigned STKSIZE = 12,
  parameter int unsigned DADDLEN = 10,
  parameter int unsigned CADDLEN = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [CADDLEN-1:0] cod_addr,
  input  logic [BITSIZE-1:0] cod_data,
  output logic [DADDLEN-1:0] dat_addr,
  input  logic [BITSIZE-1:0] dat_rdata,
  output logic [BITSIZE-1:0] dat_wdata,
  output logic               dat_we,
  input  logic               in_valid,
  input  logic [BITSIZE-1:0] in_data,
  output logic               in_pop,
  input  logic               out_full,
  output logic [BITSIZE-1:0] out_data,
  output logic               out_push,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned SPW  = $clog2(STKSIZE + 1);
  localparam int unsigned DEPW = CADDLEN + 1;

  localparam logic [BITSIZE-1:0] OP_INC   = BITSIZE'(8'h2B);
  localparam logic [BITSIZE-1:0] OP_DEC   = BITSIZE'(8'h2D);
  localparam logic [BITSIZE-1:0] OP_RIGHT = BITSIZE'(8'h3E);
  localparam logic [BITSIZE-1:0] OP_LEFT  = BITSIZE'(8'h3C);
  localparam logic [BITSIZE-1:0] OP_OUT   = BITSIZE'(8'h2E);
  localparam logic [BITSIZE-1:0] OP_IN    = BITSIZE'(8'h2C);
  localparam logic [BITSIZE-1:0] OP_OPEN  = BITSIZE'(8'h5B);
  localparam logic [BITSIZE-1:0] OP_CLOSE = BITSIZE'(8'h5D);
  localparam logic [BITSIZE-1:0] OP_END   = BITSIZE'(8'h00);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SKIP,
    S_HALT,
    S_ERR
  } state_t;

  state_t             state, state_n;
  logic [CADDLEN-1:0] pc, pc_n;
  logic [DADDLEN-1:0] ptr, ptr_n;
  logic [SPW-1:0]     sp, sp_n;
  logic [DEPW-1:0]    depth, depth_n;
  logic               push;

  logic [CADDLEN-1:0] stack [STKSIZE];
  logic [SPW-1:0]     top_idx;
  logic [CADDLEN-1:0] top_pc;
  logic               pc_last;
  logic [CADDLEN-1:0] pc_inc;

  assign cod_addr = pc;
  assign dat_addr = ptr;
  assign busy     = (state == S_RUN) || (state == S_SKIP);
  assign done     = (state == S_HALT);
  assign err      = (state == S_ERR);

  // Top-of-stack index; clamped at sp==0 where the value is never used.
  assign top_idx = (sp == '0) ? '0 : sp - SPW'(1);
  assign top_pc  = stack[top_idx];
  assign pc_last = (pc == {CADDLEN{1'b1}});
  assign pc_inc  = pc + CADDLEN'(1);

  // State and pointer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      pc    <= '0;
      ptr   <= '0;
      sp    <= '0;
      depth <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ptr   <= ptr_n;
      sp    <= sp_n;
      depth <= depth_n;
    end
  end

  // Bracket stack storage; only the sp register needs a reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      stack[sp[SPW-1:0]] <= pc;
    end
  end

  // Next-state, decode and strobe logic.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    ptr_n     = ptr;
    sp_n      = sp;
    depth_n   = depth;
    push      = 1'b0;
    dat_we    = 1'b0;
    dat_wdata = '0;
    in_pop    = 1'b0;
    out_push  = 1'b0;
    out_data  = '0;

    unique case (state)
      S_IDLE, S_HALT, S_ERR: begin
        if (START) begin
          state_n = S_RUN;
          pc_n    = '0;
          ptr_n   = '0;
          sp_n    = '0;
          depth_n = '0;
        end
      end

      S_RUN: begin
        unique case (cod_data)
          OP_INC: begin
            dat_we    = 1'b1;
            dat_wdata = dat_rdata + BITSIZE'(1);
            if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
          end
          OP_DEC: begin
            dat_we    = 1'b1;
            dat_wdata = dat_rdata - BITSIZE'(1);
            if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
          end
          OP_RIGHT: begin
            ptr_n = ptr + DADDLEN'(1);
            if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
          end
          OP_LEFT: begin
            ptr_n = ptr - DADDLEN'(1);
            if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
          end
          OP_OUT: begin
            // Stall with no side effect while the output queue is full.
            if (!out_full) begin
              out_push = 1'b1;
              out_data = dat_rdata;
              if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
            end
          end
          OP_IN: begin
            if (in_valid) begin
              in_pop    = 1'b1;
              dat_we    = 1'b1;
              dat_wdata = in_data;
              if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
            end
          end
          OP_OPEN: begin
            if (dat_rdata != '0) begin
              if (sp == SPW'(STKSIZE)) begin
                state_n = S_ERR;
              end else begin
                push = 1'b1;
                sp_n = sp + SPW'(1);
                if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
              end
            end else begin
              depth_n = DEPW'(1);
              if (pc_last) begin
                state_n = S_HALT;
              end else begin
                pc_n    = pc_inc;
                state_n = S_SKIP;
              end
            end
          end
          OP_CLOSE: begin
            if (sp == '0) begin
              state_n = S_ERR;
            end else if (dat_rdata != '0) begin
              // Jump straight to the first body opcode; no bubble.
              pc_n = top_pc + CADDLEN'(1);
            end else begin
              sp_n = sp - SPW'(1);
              if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
            end
          end
          OP_END: begin
            state_n = S_HALT;
          end
          default: begin
            if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
          end
        endcase
      end

      S_SKIP: begin
        unique case (cod_data)
          OP_OPEN: begin
            depth_n = depth + DEPW'(1);
            if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
          end
          OP_CLOSE: begin
            depth_n = depth - DEPW'(1);
            if (pc_last) begin
              state_n = S_HALT;
            end else begin
              pc_n = pc_inc;
              if (depth == DEPW'(1)) state_n = S_RUN;
            end
          end
          OP_END: begin
            state_n = S_ERR;
          end
          default: begin
            if (pc_last) state_n = S_HALT; else pc_n = pc_inc;
          end
        endcase
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Reset dominates: nothing retires in a cycle that is being reset.
    if (RST) begin
      push      = 1'b0;
      dat_we    = 1'b0;
      dat_wdata = '0;
      in_pop    = 1'b0;
      out_push  = 1'b0;
      out_data  = '0;
    end
  end

endmodule

// File: tb/tb_bf_sequencer.sv
// Directed bench for bf_sequencer: behavioural code/data RAMs, a single-entry
// input source and a push log, with expected values worked out by hand.
module tb_bf_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [9:0] cod_addr;
  logic [7:0] cod_data;
  logic [9:0] dat_addr;
  logic [7:0] dat_rdata;
  logic [7:0] dat_wdata;
  logic       dat_we;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_pop;
  logic       out_full;
  logic [7:0] out_data;
  logic       out_push;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] cmem [1024];
  logic [7:0] dmem [1024];
  logic       clr_mem;
  logic       poke_en;
  logic [9:0] poke_addr;
  logic [7:0] poke_val;

  logic [7:0] wlog [$];
  logic [7:0] olog [$];
  int         pops;
  int         checks;
  int         errors;

  always #5 CLK = ~CLK;

  bf_sequencer dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .cod_addr (cod_addr),
    .cod_data (cod_data),
    .dat_addr (dat_addr),
    .dat_rdata(dat_rdata),
    .dat_wdata(dat_wdata),
    .dat_we   (dat_we),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_pop   (in_pop),
    .out_full (out_full),
    .out_data (out_data),
    .out_push (out_push),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  assign cod_data  = cmem[cod_addr];
  assign dat_rdata = dmem[dat_addr];

  // Data RAM write port plus bench-side clear/preset, and event logging.
  always @(posedge CLK) begin
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 8'h00;
    end
    if (poke_en) dmem[poke_addr] <= poke_val;
    if (dat_we) begin
      dmem[dat_addr] <= dat_wdata;
      wlog.push_back(dat_wdata);
    end
    if (out_push) olog.push_back(out_data);
    if (in_pop) pops = pops + 1;
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_prog(input string s);
    for (int i = 0; i < 1024; i++) cmem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) cmem[i] = s[i];
  endtask

  task automatic clear_data();
    clr_mem = 1'b1;
    tick();
    clr_mem = 1'b0;
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] v);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_val  = v;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic start_run();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Bounded wait for HALT or ERR; an expired budget counts as a failure.
  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(done || err), 32'd1);
  endtask

  int wb;
  int ob;

  initial begin
    checks    = 0;
    errors    = 0;
    pops      = 0;
    RST       = 1'b1;
    START     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_full  = 1'b0;
    clr_mem   = 1'b0;
    poke_en   = 1'b0;
    poke_addr = '0;
    poke_val  = '0;
    load_prog("");
    tick();
    clear_data();
    tick();

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pc", 32'(cod_addr), 32'd0);
    check("rst_strobes", {29'd0, dat_we, in_pop, out_push}, 32'd0);
    check("rst_wdata", 32'(dat_wdata), 32'd0);
    RST = 1'b0;
    tick();

    // "+++." : writes 1,2,3, pushes 3, HALT after the fifth opcode edge.
    load_prog("+++.");
    wb = wlog.size();
    ob = olog.size();
    start_run();
    check("t1_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    check("t1_done_early", 32'(done), 32'd0);
    check("t1_pc4", 32'(cod_addr), 32'd4);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_nwr", 32'(wlog.size() - wb), 32'd3);
    if (wlog.size() - wb == 3) begin
      check("t1_w0", 32'(wlog[wb]), 32'd1);
      check("t1_w1", 32'(wlog[wb+1]), 32'd2);
      check("t1_w2", 32'(wlog[wb+2]), 32'd3);
    end
    check("t1_nout", 32'(olog.size() - ob), 32'd1);
    if (olog.size() - ob == 1) check("t1_o0", 32'(olog[ob]), 32'd3);

    // ",[-.]" with input 2: writes 2,1,0 and pushes 1,0.
    clear_data();
    load_prog(",[-.]");
    in_valid = 1'b1;
    in_data  = 8'd2;
    wb = wlog.size();
    ob = olog.size();
    pops = 0;
    start_run();
    wait_end("t2", 40);
    in_valid = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_pops", 32'(pops), 32'd1);
    check("t2_nwr", 32'(wlog.size() - wb), 32'd3);
    if (wlog.size() - wb == 3) begin
      check("t2_w0", 32'(wlog[wb]), 32'd2);
      check("t2_w1", 32'(wlog[wb+1]), 32'd1);
      check("t2_w2", 32'(wlog[wb+2]), 32'd0);
    end
    check("t2_nout", 32'(olog.size() - ob), 32'd2);
    if (olog.size() - ob == 2) begin
      check("t2_o0", 32'(olog[ob]), 32'd1);
      check("t2_o1", 32'(olog[ob+1]), 32'd0);
    end
    check("t2_pc", 32'(cod_addr), 32'd5);

    // "[+++]." on a zero cell: skipped body, one push of 0.
    clear_data();
    load_prog("[+++].");
    wb = wlog.size();
    ob = olog.size();
    start_run();
    tick();
    check("t3_skip_busy", 32'(busy), 32'd1);
    wait_end("t3", 20);
    check("t3_done", 32'(done), 32'd1);
    check("t3_nwr", 32'(wlog.size() - wb), 32'd0);
    check("t3_nout", 32'(olog.size() - ob), 32'd1);
    if (olog.size() - ob == 1) check("t3_o0", 32'(olog[ob]), 32'd0);
    check("t3_pc", 32'(cod_addr), 32'd6);

    // "." stalled by out_full for 4 cycles.
    load_prog(".");
    out_full = 1'b1;
    start_run();
    for (int i = 0; i < 4; i++) begin
      check("t4_stall_push", 32'(out_push), 32'd0);
      check("t4_stall_pc", 32'(cod_addr), 32'd0);
      tick();
    end
    out_full = 1'b0;
    #1;
    check("t4_push", 32'(out_push), 32'd1);
    check("t4_pdata", 32'(out_data), 32'd0);
    tick();
    check("t4_pc1", 32'(cod_addr), 32'd1);
    tick();
    check("t4_done", 32'(done), 32'd1);

    // 13 nested '[' on a nonzero cell overflow the 12-entry stack.
    poke(10'd0, 8'd1);
    load_prog("[[[[[[[[[[[[[");
    start_run();
    repeat (12) tick();
    check("t5_err_early", 32'(err), 32'd0);
    check("t5_pc12", 32'(cod_addr), 32'd12);
    tick();
    check("t5_err", 32'(err), 32'd1);
    tick();
    check("t5_hold_pc", 32'(cod_addr), 32'd12);

    // "]" with an empty stack.
    load_prog("]");
    start_run();
    check("t5b_busy", 32'(busy), 32'd1);
    tick();
    check("t5b_err", 32'(err), 32'd1);

    // "[[]" on a zero cell: unmatched bracket found at the 0x00.
    poke(10'd0, 8'd0);
    load_prog("[[]");
    start_run();
    repeat (3) tick();
    check("t5c_err_early", 32'(err), 32'd0);
    tick();
    check("t5c_err", 32'(err), 32'd1);
    check("t5c_pc", 32'(cod_addr), 32'd3);

    // "<-." : pointer wraps to 1023, cell wraps to 0xFF and is output.
    clear_data();
    load_prog("<-.");
    wb = wlog.size();
    ob = olog.size();
    start_run();
    tick();
    check("t6_ptr", 32'(dat_addr), 32'd1023);
    check("t6_dec_wdata", 32'(dat_wdata), 32'hFF);
    wait_end("t6", 10);
    check("t6_done", 32'(done), 32'd1);
    check("t6_ptr_hold", 32'(dat_addr), 32'd1023);
    check("t6_nout", 32'(olog.size() - ob), 32'd1);
    if (olog.size() - ob == 1) check("t6_o0", 32'(olog[ob]), 32'hFF);

    // RST mid-SKIP returns to IDLE with every output cleared.
    clear_data();
    load_prog(">[+++]");
    start_run();
    repeat (3) tick();
    check("t7_ptr1", 32'(dat_addr), 32'd1);
    check("t7_skip_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_err", 32'(err), 32'd0);
    check("t7_pc", 32'(cod_addr), 32'd0);
    check("t7_ptr", 32'(dat_addr), 32'd0);
    check("t7_strobes", {29'd0, dat_we, in_pop, out_push}, 32'd0);
    check("t7_data", {16'd0, dat_wdata, out_data}, 32'd0);
    tick();
    check("t7_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
